vregs_param: RTL and testbench
==============================

// Module: vregs_param
// PURPOSE
//  Parametrised vector register file: NREGS registers of NELEM elements x EW bits, each with a length field.
//  Two combinational whole-vector read ports plus one combinational single-element read port.
//  One 1-cycle whole-vector write port plus a handshaked element-stream write sequencer; a per-register busy bit tracks in-flight streams.
//  Sits between vector decode/issue (reads, busy check) and the vector ALU/load unit (writes).
// PARAMETERS
//  NREGS  16                    number of vector registers
//  NELEM  16                    elements per register
//  EW     16                    element width, bits
//  AW     $clog2(NREGS)         register address width
//  IW     $clog2(NELEM)         element index width
//  LW     $clog2(NELEM+1)       length width; legal lengths 0..NELEM
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  r_addr0    in   AW        read port 0 register
//  r_data0    out  NELEM*EW  read port 0 vector, element i at [i*EW +: EW]
//  r_len0     out  LW        read port 0 length
//  r_busy0    out  1         read port 0 register has a stream in flight
//  r_addr1/r_data1/r_len1/r_busy1   same as port 0
//  e_addr     in   AW        element read register
//  e_idx      in   IW        element read index
//  e_data     out  EW        element read data
//  w_en       in   1         whole-vector write strobe
//  w_addr     in   AW        whole-vector write register
//  w_len      in   LW        whole-vector write length
//  w_data     in   NELEM*EW  whole-vector write data
//  w_conflict out  1         registered 1-cycle pulse: w_en dropped, target busy
//  s_start    in   1         begin stream into s_addr with s_len elements
//  s_addr     in   AW        stream target register
//  s_len      in   LW        stream element count
//  s_valid    in   1         stream element valid
//  s_data     in   EW        stream element data
//  s_ready    out  1         sequencer accepts element this cycle
//  s_active   out  1         sequencer not IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): all data=0, all len=0, all busy=0, FSM=IDLE, s_ready=0, s_active=0, w_conflict=0.
//  - Reads: 0-cycle combinational. e_data=0 when e_idx >= len of e_addr.
//  - Whole write: w_en at edge N updates data+len of w_addr, visible on reads after edge N. Dropped if busy[w_addr]=1 or the sequencer
//    targets w_addr this cycle (including s_start); w_conflict=1 for the following cycle. w_len > NELEM clamps to NELEM.
//  - Sequencer FSM: IDLE, STREAM.
//    IDLE: s_start with s_len=0 -> len[s_addr]=0, data untouched, stay IDLE, busy not set.
//          s_start with s_len>0 -> latch addr, clamp len to NELEM, cnt=0, busy[s_addr]=1, go STREAM.
//    STREAM: s_ready=1 unless w_en=1 this cycle (whole write has bus priority; element stalls).
//          s_valid&s_ready -> data[addr][cnt]=s_data, cnt++. On final element: len[addr]=latched len,
//          busy[addr]=0, go IDLE on the same edge; s_ready=0 next cycle.
//    s_start while STREAM is ignored (issue must check s_active). Elements at index >= s_len keep old values.
//  - Busy visible on r_busyN the cycle after s_start edge, cleared the cycle after the last element edge.
//  - Reset mid-stream: register contents zeroed, FSM to IDLE, partial stream discarded.
// CONFIGURATION
//  VREGS_BYPASS_EN defined: accepted w_en write and accepted stream element are forwarded combinationally to r_data0/1, r_len0/1
//    and e_data in the same cycle (stream updates length only on the final element).
//  Undefined: reads return pre-edge contents; new values visible from the next cycle.
// STRUCTURE
//  Package vregs_pkg: NREGS/NELEM/EW defaults, derived AW/IW/LW, typedef elem_t, vec_t, len_t, enum seq_state_t {IDLE, STREAM}.
//  Sub-module vregs_stream_seq: FSM, counter, latched addr/len, handshake; emits element write enable/addr/idx/data,
//    length commit and busy set/clear strobes. Storage, read muxes, busy vector, arbitration stay in top level.
// TESTING
//  1 Reset: rst_n low mid-run -> all r_data0/1=0, r_len=0, r_busy=0, s_ready=0 immediately (async).
//  2 w_en, w_addr=3, w_len=8, w_data=ramp 0..15 -> next cycle r_addr0=3 gives ramp, r_len0=8; e_idx=9 -> e_data=0.
//  3 s_start addr=5 len=4, elements 0xA0..0xA3 with s_valid gap after 2nd -> r_busy0=1 during stream, len[5]=4 and busy=0 after 4th.
//  4 During stream to reg 5, w_en to reg 5 -> write dropped, w_conflict pulses 1 cycle; w_en to reg 6 -> s_ready=0 that cycle, reg 6 written.
//  5 s_start len=0 to reg 2 (was len 8) -> len[2]=0, s_active stays 0; s_start len=20 -> clamps, accepts exactly 16 elements.
//  6 VREGS_BYPASS_EN: w_en addr=1, r_addr0=1 same cycle -> r_data0 equals w_data combinationally; without macro -> old value.

Source files
------------

// File: rtl/vregs_pkg.sv
// Shared types and default geometry for the vector register file.
package vregs_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned NELEM = 16;
  localparam int unsigned EW    = 16;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned IW    = $clog2(NELEM);
  localparam int unsigned LW    = $clog2(NELEM + 1);

  typedef logic [EW-1:0]       elem_t;
  typedef logic [NELEM*EW-1:0] vec_t;
  typedef logic [LW-1:0]       len_t;

  typedef enum logic {
    IDLE,
    STREAM
  } seq_state_t;

endpackage

// File: rtl/vregs_stream_seq.sv
// Element-stream write sequencer: latches target and length, walks the element index,
// and emits element-write, length-commit and busy set/clear strobes to the register file.
module vregs_stream_seq
  import vregs_pkg::*;
#(
  parameter int unsigned NELEM = vregs_pkg::NELEM,
  parameter int unsigned EW    = vregs_pkg::EW,
  parameter int unsigned AW    = vregs_pkg::AW,
  parameter int unsigned IW    = vregs_pkg::IW,
  parameter int unsigned LW    = vregs_pkg::LW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] startAddr,
  input  logic [LW-1:0] startLen,
  input  logic          valid,
  input  logic [EW-1:0] data,
  input  logic          stall,
  output logic          ready,
  output logic          active,
  output logic          elemWe,
  output logic [AW-1:0] elemAddr,
  output logic [IW-1:0] elemIdx,
  output logic [EW-1:0] elemData,
  output logic          lenWe,
  output logic [AW-1:0] lenAddr,
  output logic [LW-1:0] lenVal,
  output logic          busySet,
  output logic          busyClr,
  output logic [AW-1:0] busyAddr,
  output logic          tgtValid,
  output logic [AW-1:0] tgtAddr
);

  seq_state_t    stateQ, stateD;
  logic [AW-1:0] addrQ, addrD;
  logic [LW-1:0] lenQ, lenD;
  logic [LW-1:0] cntQ, cntD;
  logic [LW-1:0] startLenClamped;
  logic [LW-1:0] cntNext;

  assign startLenClamped = (startLen > LW'(NELEM)) ? LW'(NELEM) : startLen;
  assign cntNext         = cntQ + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      addrQ  <= '0;
      lenQ   <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      lenQ   <= lenD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    addrD    = addrQ;
    lenD     = lenQ;
    cntD     = cntQ;
    ready    = 1'b0;
    elemWe   = 1'b0;
    lenWe    = 1'b0;
    lenAddr  = addrQ;
    lenVal   = lenQ;
    busySet  = 1'b0;
    busyClr  = 1'b0;
    busyAddr = addrQ;
    tgtValid = 1'b0;
    tgtAddr  = addrQ;
    case (stateQ)
      IDLE: begin
        tgtAddr = startAddr;
        if (start) begin
          tgtValid = 1'b1;
          if (startLenClamped == '0) begin
            // Empty stream only truncates the length; data is left alone.
            lenWe   = 1'b1;
            lenAddr = startAddr;
            lenVal  = '0;
          end else begin
            busySet  = 1'b1;
            busyAddr = startAddr;
            addrD    = startAddr;
            lenD     = startLenClamped;
            cntD     = '0;
            stateD   = STREAM;
          end
        end
      end
      STREAM: begin
        tgtValid = 1'b1;
        // A whole-vector write owns the write bus this cycle.
        ready = !stall;
        if (valid && ready) begin
          elemWe = 1'b1;
          cntD   = cntNext;
          if (cntNext == lenQ) begin
            lenWe   = 1'b1;
            busyClr = 1'b1;
            stateD  = IDLE;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign active   = (stateQ == STREAM);
  assign elemAddr = addrQ;
  assign elemIdx  = cntQ[IW-1:0];
  assign elemData = data;

endmodule

// File: rtl/vregs_param.sv
// Vector register file with two vector read ports, one element read port, a whole-vector write
// port and a streamed element writer. Define VREGS_BYPASS_EN to forward same-cycle writes to reads.
module vregs_param
  import vregs_pkg::*;
#(
  parameter int unsigned NREGS = vregs_pkg::NREGS,
  parameter int unsigned NELEM = vregs_pkg::NELEM,
  parameter int unsigned EW    = vregs_pkg::EW,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned IW    = $clog2(NELEM),
  parameter int unsigned LW    = $clog2(NELEM + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       r_addr0,
  output logic [NELEM*EW-1:0] r_data0,
  output logic [LW-1:0]       r_len0,
  output logic                r_busy0,
  input  logic [AW-1:0]       r_addr1,
  output logic [NELEM*EW-1:0] r_data1,
  output logic [LW-1:0]       r_len1,
  output logic                r_busy1,
  input  logic [AW-1:0]       e_addr,
  input  logic [IW-1:0]       e_idx,
  output logic [EW-1:0]       e_data,
  input  logic                w_en,
  input  logic [AW-1:0]       w_addr,
  input  logic [LW-1:0]       w_len,
  input  logic [NELEM*EW-1:0] w_data,
  output logic                w_conflict,
  input  logic                s_start,
  input  logic [AW-1:0]       s_addr,
  input  logic [LW-1:0]       s_len,
  input  logic                s_valid,
  input  logic [EW-1:0]       s_data,
  output logic                s_ready,
  output logic                s_active
);

  localparam int unsigned NPORTS = 3;

  logic [NELEM*EW-1:0] dataQ [NREGS];
  logic [LW-1:0]       lenQ  [NREGS];
  logic [NREGS-1:0]    busyQ;
  logic                conflictQ;

  logic          elemWe, lenWe, busySet, busyClr, tgtValid;
  logic [AW-1:0] elemAddr, lenAddr, busyAddr, tgtAddr;
  logic [IW-1:0] elemIdx;
  logic [EW-1:0] elemData;
  logic [LW-1:0] lenVal;

  logic          wHit, wAccept;
  logic [LW-1:0] wLenClamped;

  vregs_stream_seq #(
    .NELEM(NELEM),
    .EW   (EW),
    .AW   (AW),
    .IW   (IW),
    .LW   (LW)
  ) uSeq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s_start),
    .startAddr(s_addr),
    .startLen (s_len),
    .valid    (s_valid),
    .data     (s_data),
    .stall    (w_en),
    .ready    (s_ready),
    .active   (s_active),
    .elemWe   (elemWe),
    .elemAddr (elemAddr),
    .elemIdx  (elemIdx),
    .elemData (elemData),
    .lenWe    (lenWe),
    .lenAddr  (lenAddr),
    .lenVal   (lenVal),
    .busySet  (busySet),
    .busyClr  (busyClr),
    .busyAddr (busyAddr),
    .tgtValid (tgtValid),
    .tgtAddr  (tgtAddr)
  );

  // A whole write never lands on a register the sequencer owns or is about to claim.
  assign wHit        = busyQ[w_addr] || (tgtValid && (tgtAddr == w_addr));
  assign wAccept     = w_en && !wHit;
  assign wLenClamped = (w_len > LW'(NELEM)) ? LW'(NELEM) : w_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        dataQ[r] <= '0;
        lenQ[r]  <= '0;
      end
      busyQ     <= '0;
      conflictQ <= 1'b0;
    end else begin
      if (wAccept) begin
        dataQ[w_addr] <= w_data;
        lenQ[w_addr]  <= wLenClamped;
      end
      if (elemWe) dataQ[elemAddr][int'(elemIdx)*EW +: EW] <= elemData;
      if (lenWe) lenQ[lenAddr] <= lenVal;
      if (busySet) busyQ[busyAddr] <= 1'b1;
      if (busyClr) busyQ[busyAddr] <= 1'b0;
      conflictQ <= w_en && wHit;
    end
  end

  logic [AW-1:0]       rdAddr [NPORTS];
  logic [NELEM*EW-1:0] rdVec  [NPORTS];
  logic [LW-1:0]       rdLen  [NPORTS];

  assign rdAddr[0] = r_addr0;
  assign rdAddr[1] = r_addr1;
  assign rdAddr[2] = e_addr;

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rdVec[p] = dataQ[rdAddr[p]];
      rdLen[p] = lenQ[rdAddr[p]];
`ifdef VREGS_BYPASS_EN
      if (wAccept && (w_addr == rdAddr[p])) begin
        rdVec[p] = w_data;
        rdLen[p] = wLenClamped;
      end
      if (elemWe && (elemAddr == rdAddr[p])) rdVec[p][int'(elemIdx)*EW +: EW] = elemData;
      if (lenWe && (lenAddr == rdAddr[p])) rdLen[p] = lenVal;
`endif
    end
  end

  assign r_data0    = rdVec[0];
  assign r_len0     = rdLen[0];
  assign r_busy0    = busyQ[r_addr0];
  assign r_data1    = rdVec[1];
  assign r_len1     = rdLen[1];
  assign r_busy1    = busyQ[r_addr1];
  assign e_data     = (LW'(e_idx) < rdLen[2]) ? rdVec[2][int'(e_idx)*EW +: EW] : '0;
  assign w_conflict = conflictQ;

endmodule

// File: tb/tb_vregs_param.sv
// Self-checking bench for vregs_param against an array-based reference model.
module tb_vregs_param;

  localparam int NREGS = 16;
  localparam int NELEM = 16;
  localparam int EW    = 16;
  localparam int AW    = 4;
  localparam int IW    = 4;
  localparam int LW    = 5;
  localparam int VW    = NELEM * EW;

  logic          clk, rst_n;
  logic [AW-1:0] r_addr0, r_addr1, e_addr, w_addr, s_addr;
  logic [VW-1:0] r_data0, r_data1, w_data;
  logic [LW-1:0] r_len0, r_len1, w_len, s_len;
  logic          r_busy0, r_busy1;
  logic [IW-1:0] e_idx;
  logic [EW-1:0] e_data, s_data;
  logic          w_en, w_conflict, s_start, s_valid, s_ready, s_active;

  vregs_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_addr0   (r_addr0),
    .r_data0   (r_data0),
    .r_len0    (r_len0),
    .r_busy0   (r_busy0),
    .r_addr1   (r_addr1),
    .r_data1   (r_data1),
    .r_len1    (r_len1),
    .r_busy1   (r_busy1),
    .e_addr    (e_addr),
    .e_idx     (e_idx),
    .e_data    (e_data),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_len     (w_len),
    .w_data    (w_data),
    .w_conflict(w_conflict),
    .s_start   (s_start),
    .s_addr    (s_addr),
    .s_len     (s_len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .s_active  (s_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  int refData [NREGS][NELEM];
  int refLen  [NREGS];
  bit refBusy [NREGS];
  bit refConflict;
  bit mActive;
  int mAddr, mLen, mCnt;

  int nChecks, nPass;

`ifdef VREGS_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  function automatic logic [VW-1:0] expVec(int a);
    logic [VW-1:0] v;
    for (int i = 0; i < NELEM; i++) v[i*EW +: EW] = EW'(refData[a][i]);
    return v;
  endfunction

  function automatic logic [EW-1:0] expElem(int a, int i);
    return (i < refLen[a]) ? EW'(refData[a][i]) : '0;
  endfunction

  function automatic int clampLen(int l);
    return (l > NELEM) ? NELEM : l;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      for (int i = 0; i < NELEM; i++) refData[r][i] = 0;
      refLen[r]  = 0;
      refBusy[r] = 1'b0;
    end
    refConflict = 1'b0;
    mActive = 1'b0;
    mAddr = 0;
    mLen = 0;
    mCnt = 0;
  endtask

  task automatic clear_strobes();
    w_en = 1'b0;
    s_start = 1'b0;
    s_valid = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs, updating the model in step.
  task automatic step();
    bit drop, rdy;
    rdy  = mActive && !w_en;
    drop = w_en && (refBusy[w_addr] || (mActive && mAddr == int'(w_addr)) ||
                    (!mActive && s_start && s_addr == w_addr));
    @(posedge clk);
    refConflict = drop;
    if (w_en && !drop) begin
      for (int i = 0; i < NELEM; i++) refData[w_addr][i] = int'(w_data[i*EW +: EW]);
      refLen[w_addr] = clampLen(int'(w_len));
    end
    if (!mActive) begin
      if (s_start) begin
        if (s_len == 0) refLen[s_addr] = 0;
        else begin
          mActive = 1'b1;
          mAddr = int'(s_addr);
          mLen = clampLen(int'(s_len));
          mCnt = 0;
          refBusy[s_addr] = 1'b1;
        end
      end
    end else if (s_valid && rdy) begin
      refData[mAddr][mCnt] = int'(s_data);
      mCnt++;
      if (mCnt == mLen) begin
        refLen[mAddr] = mLen;
        refBusy[mAddr] = 1'b0;
        mActive = 1'b0;
      end
    end
    #1;
    clear_strobes();
  endtask

  task automatic test_reset();
    w_en = 1'b1; w_addr = 4; w_len = 10;
    for (int i = 0; i < NELEM; i++) w_data[i*EW +: EW] = EW'(16'h1111 * (i + 1));
    step();
    s_start = 1'b1; s_addr = 9; s_len = 5;
    step();
    s_valid = 1'b1; s_data = 16'hBEEF;
    step();
    nChecks++;
    if (s_ready !== mActive) $display("FAIL pre_reset_ready: got %b want %b", s_ready, mActive);
    else nPass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    nChecks++;
    if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready);
    else nPass++;
    nChecks++;
    if (s_active !== 1'b0) $display("FAIL reset_s_active: got %b want 0", s_active);
    else nPass++;
    nChecks++;
    if (w_conflict !== 1'b0) $display("FAIL reset_w_conflict: got %b want 0", w_conflict);
    else nPass++;
    for (int r = 0; r < NREGS; r++) begin
      r_addr0 = AW'(r);
      r_addr1 = AW'(NREGS - 1 - r);
      #1;
      nChecks++;
      if (r_data0 !== expVec(r) || r_len0 !== LW'(refLen[r]) || r_busy0 !== refBusy[r])
        $display("FAIL reset_port0 reg %0d: got %h/%0d/%b want zero", r, r_data0, r_len0, r_busy0);
      else nPass++;
      nChecks++;
      if (r_data1 !== expVec(NREGS - 1 - r) || r_len1 !== '0 || r_busy1 !== 1'b0)
        $display("FAIL reset_port1 reg %0d: got %h/%0d/%b want zero", NREGS - 1 - r, r_data1,
                 r_len1, r_busy1);
      else nPass++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_whole_write();
    w_en = 1'b1; w_addr = 3; w_len = 8;
    for (int i = 0; i < NELEM; i++) w_data[i*EW +: EW] = EW'(i);
    step();
    r_addr0 = 3; e_addr = 3; e_idx = 9;
    #1;
    nChecks++;
    if (r_data0 !== expVec(3)) $display("FAIL ww_data: got %h want %h", r_data0, expVec(3));
    else nPass++;
    nChecks++;
    if (r_len0 !== 5'd8) $display("FAIL ww_len: got %0d want 8", r_len0);
    else nPass++;
    nChecks++;
    if (e_data !== 16'd0) $display("FAIL ww_elem_past_len: got %h want 0", e_data);
    else nPass++;
    e_idx = 5;
    #1;
    nChecks++;
    if (e_data !== expElem(3, 5)) $display("FAIL ww_elem5: got %h want %h", e_data, expElem(3, 5));
    else nPass++;
  endtask

  task automatic test_stream();
    logic [EW-1:0] elems [4];
    bit gap [4];
    elems = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
    gap = '{1'b0, 1'b0, 1'b1, 1'b0};
    s_start = 1'b1; s_addr = 5; s_len = 4;
    step();
    r_addr0 = 5; e_addr = 5;
    #1;
    nChecks++;
    if (r_busy0 !== 1'b1) $display("FAIL st_busy_set: got %b want 1", r_busy0);
    else nPass++;
    for (int k = 0; k < 4; k++) begin
      if (gap[k]) step();
      s_valid = 1'b1; s_data = elems[k];
      #1;
      nChecks++;
      if (s_ready !== 1'b1 || r_busy0 !== 1'b1)
        $display("FAIL st_handshake %0d: ready %b busy %b want 1 1", k, s_ready, r_busy0);
      else nPass++;
      step();
    end
    nChecks++;
    if (r_busy0 !== 1'b0 || s_active !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL st_done: busy %b active %b ready %b want 0 0 0", r_busy0, s_active, s_ready);
    else nPass++;
    nChecks++;
    if (r_len0 !== 5'd4) $display("FAIL st_len: got %0d want 4", r_len0);
    else nPass++;
    for (int k = 0; k < 4; k++) begin
      e_idx = IW'(k);
      #1;
      nChecks++;
      if (e_data !== elems[k]) $display("FAIL st_elem %0d: got %h want %h", k, e_data, elems[k]);
      else nPass++;
    end
  endtask

  task automatic test_conflict();
    s_start = 1'b1; s_addr = 5; s_len = 3;
    step();
    w_en = 1'b1; w_addr = 5; w_len = 2; w_data = '1;
    s_valid = 1'b1; s_data = 16'hB0;
    #1;
    nChecks++;
    if (s_ready !== 1'b0) $display("FAIL cf_stall_same: got %b want 0", s_ready);
    else nPass++;
    step();
    r_addr0 = 5;
    #1;
    nChecks++;
    if (w_conflict !== 1'b1) $display("FAIL cf_pulse: got %b want 1", w_conflict);
    else nPass++;
    nChecks++;
    if (r_len0 !== LW'(refLen[5]) || r_data0 !== expVec(5))
      $display("FAIL cf_dropped: got %0d/%h want %0d/%h", r_len0, r_data0, refLen[5], expVec(5));
    else nPass++;
    step();
    nChecks++;
    if (w_conflict !== 1'b0) $display("FAIL cf_pulse_end: got %b want 0", w_conflict);
    else nPass++;
    w_en = 1'b1; w_addr = 6; w_len = 12;
    for (int i = 0; i < NELEM; i++) w_data[i*EW +: EW] = EW'(16'h6000 + i);
    s_valid = 1'b1; s_data = 16'hB0;
    #1;
    nChecks++;
    if (s_ready !== 1'b0) $display("FAIL cf_stall_other: got %b want 0", s_ready);
    else nPass++;
    step();
    r_addr1 = 6;
    #1;
    nChecks++;
    if (r_data1 !== expVec(6) || r_len1 !== 5'd12 || w_conflict !== 1'b0)
      $display("FAIL cf_other_write: got %h/%0d/%b want %h/12/0", r_data1, r_len1, w_conflict,
               expVec(6));
    else nPass++;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = EW'(16'hB0 + k);
      step();
    end
    nChecks++;
    if (r_len0 !== 5'd3 || r_busy0 !== 1'b0 || r_data0 !== expVec(5))
      $display("FAIL cf_stream_end: got %0d/%b/%h want 3/0/%h", r_len0, r_busy0, r_data0,
               expVec(5));
    else nPass++;
  endtask

  task automatic test_zero_and_clamp();
    w_en = 1'b1; w_addr = 2; w_len = 8;
    for (int i = 0; i < NELEM; i++) w_data[i*EW +: EW] = EW'($urandom);
    step();
    s_start = 1'b1; s_addr = 2; s_len = 0;
    step();
    r_addr0 = 2;
    #1;
    nChecks++;
    if (r_len0 !== 5'd0 || s_active !== 1'b0 || r_busy0 !== 1'b0)
      $display("FAIL zl_len0: len %0d active %b busy %b want 0 0 0", r_len0, s_active, r_busy0);
    else nPass++;
    nChecks++;
    if (r_data0 !== expVec(2)) $display("FAIL zl_data_kept: got %h want %h", r_data0, expVec(2));
    else nPass++;
    s_start = 1'b1; s_addr = 7; s_len = 20;
    step();
    for (int k = 0; k < NELEM; k++) begin
      s_valid = 1'b1; s_data = EW'($urandom);
      #1;
      nChecks++;
      if (s_ready !== 1'b1) $display("FAIL clamp_ready %0d: got %b want 1", k, s_ready);
      else nPass++;
      step();
    end
    r_addr0 = 7;
    #1;
    nChecks++;
    if (s_active !== 1'b0 || s_ready !== 1'b0 || r_len0 !== 5'd16 || r_data0 !== expVec(7))
      $display("FAIL clamp_done: active %b ready %b len %0d data %h want 0 0 16 %h", s_active,
               s_ready, r_len0, r_data0, expVec(7));
    else nPass++;
  endtask

  task automatic test_bypass();
    logic [VW-1:0] oldVec;
    logic [LW-1:0] oldLen;
    r_addr0 = 1;
    oldVec = expVec(1);
    oldLen = LW'(refLen[1]);
    w_en = 1'b1; w_addr = 1; w_len = 6;
    for (int i = 0; i < NELEM; i++) w_data[i*EW +: EW] = EW'(16'hC000 + i * 7 + 1);
    #1;
    nChecks++;
    if (r_data0 !== (Bypass ? w_data : oldVec) || r_len0 !== (Bypass ? LW'(6) : oldLen))
      $display("FAIL bypass_same_cycle: got %h/%0d want %h/%0d", r_data0, r_len0,
               Bypass ? w_data : oldVec, Bypass ? LW'(6) : oldLen);
    else nPass++;
    step();
    nChecks++;
    if (r_data0 !== expVec(1) || r_len0 !== 5'd6)
      $display("FAIL bypass_after: got %h/%0d want %h/6", r_data0, r_len0, expVec(1));
    else nPass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      w_en = ($urandom_range(3) == 0);
      w_addr = AW'($urandom);
      w_len = LW'($urandom_range(20));
      for (int i = 0; i < NELEM; i++) w_data[i*EW +: EW] = EW'($urandom);
      s_start = ($urandom_range(5) == 0);
      s_addr = AW'($urandom);
      s_len = LW'($urandom_range(20));
      s_valid = ($urandom_range(1) == 0);
      s_data = EW'($urandom);
      r_addr0 = AW'($urandom);
      r_addr1 = AW'($urandom);
      e_addr = AW'($urandom);
      e_idx = IW'($urandom);
      #1;
      nChecks++;
      if (s_ready !== (mActive && !w_en))
        $display("FAIL rnd_ready %0d: got %b want %b", n, s_ready, mActive && !w_en);
      else nPass++;
      step();
      nChecks++;
      if (r_data0 !== expVec(r_addr0) || r_len0 !== LW'(refLen[r_addr0]) ||
          r_busy0 !== refBusy[r_addr0])
        $display("FAIL rnd_port0 %0d: got %h/%0d/%b want %h/%0d/%b", n, r_data0, r_len0, r_busy0,
                 expVec(r_addr0), refLen[r_addr0], refBusy[r_addr0]);
      else nPass++;
      nChecks++;
      if (r_data1 !== expVec(r_addr1) || r_len1 !== LW'(refLen[r_addr1]) ||
          r_busy1 !== refBusy[r_addr1])
        $display("FAIL rnd_port1 %0d: got %h/%0d/%b want %h/%0d/%b", n, r_data1, r_len1, r_busy1,
                 expVec(r_addr1), refLen[r_addr1], refBusy[r_addr1]);
      else nPass++;
      nChecks++;
      if (e_data !== expElem(e_addr, e_idx))
        $display("FAIL rnd_elem %0d: got %h want %h", n, e_data, expElem(e_addr, e_idx));
      else nPass++;
      nChecks++;
      if (w_conflict !== refConflict || s_active !== mActive)
        $display("FAIL rnd_status %0d: conflict %b active %b want %b %b", n, w_conflict, s_active,
                 refConflict, mActive);
      else nPass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nChecks = 0;
    nPass = 0;
    rst_n = 1'b0;
    clear_strobes();
    r_addr0 = '0; r_addr1 = '0; e_addr = '0; e_idx = '0;
    w_addr = '0; w_len = '0; w_data = '0;
    s_addr = '0; s_len = '0; s_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_whole_write();
    test_stream();
    test_conflict();
    test_zero_and_clamp();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
